// File: rtl/control.sv
// Fetch/execute sequencer for the Z8 core: owns PC, IR, r0..r3 and the Z/C flags, and drives one shared byte-wide memory bus.
// Instructions take 2-5 cycles; memory is assumed combinational-read, so there is no bus stall or backpressure.
module control (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  dBusIn,
   output logic [7:0]  dBusOut,
   output logic        rWMem,
   output logic [15:0] addrBus,
   output logic [15:0] pcOutTest
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_OPLO   = 3'd2,
      S_OPHI   = 3'd3,
      S_MEM    = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_MOV  = 3'd1;
   localparam logic [2:0] OP_LDI  = 3'd2;
   localparam logic [2:0] OP_LD   = 3'd3;
   localparam logic [2:0] OP_ST   = 3'd4;
   localparam logic [2:0] OP_ALU  = 3'd5;
   localparam logic [2:0] OP_JMP  = 3'd6;
   localparam logic [2:0] OP_HALT = 3'd7;

   state_t          state_q, state_d;
   logic [15:0]     pc_q, pc_d;
   logic [7:0]      ir_q, ir_d;
   logic [7:0]      lo_q, lo_d;
   logic [7:0]      hi_q, hi_d;
   logic [3:0][7:0] rf_q, rf_d;
   logic            z_q, z_d;
   logic            c_q, c_d;

   logic            mode;
   logic [1:0]      rd;
   logic [1:0]      rs;
   logic [2:0]      op;
   logic [7:0]      rd_val;
   logic [7:0]      rs_val;
   logic [8:0]      sum;
   logic [8:0]      diff;
   logic            wr_cycle;

   assign mode   = ir_q[7];
   assign rd     = ir_q[6:5];
   assign rs     = ir_q[4:3];
   assign op     = ir_q[2:0];
   assign rd_val = rf_q[rd];
   assign rs_val = rf_q[rs];

   // Ninth bit is carry-out for ADD and borrow for SUB.
   assign sum  = {1'b0, rd_val} + {1'b0, rs_val};
   assign diff = {1'b0, rd_val} - {1'b0, rs_val};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      rf_d    = rf_q;
      z_d     = z_q;
      c_d     = c_q;

      case (state_q)
         S_FETCH: begin
            ir_d    = dBusIn;
            pc_d    = pc_q + 16'd1;
            state_d = S_DECODE;
         end

         S_DECODE: begin
            case (op)
               OP_NOP: state_d = S_FETCH;
               OP_MOV: begin
                  rf_d[rd] = rs_val;
                  state_d  = S_FETCH;
               end
               OP_ALU: begin
                  if (mode) begin
                     rf_d[rd] = diff[7:0];
                     z_d      = (diff[7:0] == 8'h00);
                     c_d      = diff[8];
                  end else begin
                     rf_d[rd] = sum[7:0];
                     z_d      = (sum[7:0] == 8'h00);
                     c_d      = sum[8];
                  end
                  state_d = S_FETCH;
               end
               OP_HALT: state_d = S_HALT;
               OP_LDI,
               OP_LD,
               OP_ST,
               OP_JMP:  state_d = S_OPLO;
            endcase
         end

         S_OPLO: begin
            pc_d = pc_q + 16'd1;
            if (op == OP_LDI) begin
               rf_d[rd] = dBusIn;
               state_d  = S_FETCH;
            end else begin
               lo_d    = dBusIn;
               state_d = S_OPHI;
            end
         end

         S_OPHI: begin
            hi_d = dBusIn;
            pc_d = pc_q + 16'd1;
            if (op == OP_JMP) begin
               // mode=1 is JZ: fall through with the incremented PC when Z is clear.
               if (!mode || z_q) begin
                  pc_d = {dBusIn, lo_q};
               end
               state_d = S_FETCH;
            end else begin
               state_d = S_MEM;
            end
         end

         S_MEM: begin
            if (op == OP_LD) begin
               rf_d[rd] = dBusIn;
            end
            state_d = S_FETCH;
         end

         S_HALT: state_d = S_HALT;

         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FETCH;
         pc_q    <= 16'h0000;
         ir_q    <= 8'h00;
         lo_q    <= 8'h00;
         hi_q    <= 8'h00;
         rf_q    <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         rf_q    <= rf_d;
         z_q     <= z_d;
         c_q     <= c_d;
      end
   end

   // Bus outputs depend only on registered state, never on dBusIn.
   assign wr_cycle  = (state_q == S_MEM) && (op == OP_ST);
   assign addrBus   = (state_q == S_MEM) ? {hi_q, lo_q} : pc_q;
   assign rWMem     = ~wr_cycle;
   assign dBusOut   = wr_cycle ? rs_val : 8'h00;
   assign pcOutTest = pc_q;

endmodule

// File: tb/tb_control.sv
// Directed programs against a combinational-read memory model; write cycles are checked by a scoreboard monitor.
module tb_control;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic        clk;
   logic        rst;
   logic [7:0]  dBusIn;
   logic [7:0]  dBusOut;
   logic        rWMem;
   logic [15:0] addrBus;
   logic [15:0] pcOutTest;

   logic [7:0]  mem [0:65535];
   wr_t         exp_q [$];
   int          n_chk;
   int          n_pass;

   control dut (
      .clk       (clk),
      .rst       (rst),
      .dBusIn    (dBusIn),
      .dBusOut   (dBusOut),
      .rWMem     (rWMem),
      .addrBus   (addrBus),
      .pcOutTest (pcOutTest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dBusIn = mem[addrBus];

   always @(posedge clk) begin
      if (rst && !rWMem) mem[addrBus] <= dBusOut;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Scoreboard monitor: every write cycle must match the oldest expected write.
   always @(negedge clk) begin
      wr_t e;
      if (rst && !rWMem) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", addrBus, dBusOut);
         end else begin
            e = exp_q.pop_front();
            chk("write_addr", {16'h0, addrBus}, {16'h0, e.addr});
            chk("write_data", {24'h0, dBusOut}, {24'h0, e.data});
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
   endtask

   task automatic put(input logic [15:0] a, input logic [7:0] d);
      mem[a] = d;
   endtask

   task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic chk_pc(input string name, input logic [15:0] exp);
      chk(name, {16'h0, pcOutTest}, {16'h0, exp});
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst    = 1'b0;
      clear_mem();

      // Reset state
      @(negedge clk);
      chk("rst_addr", {16'h0, addrBus}, 32'h0);
      chk("rst_rw", {31'h0, rWMem}, 32'h1);
      chk("rst_dout", {24'h0, dBusOut}, 32'h0);
      chk_pc("rst_pc", 16'h0000);

      // All-NOP memory: PC advances once per two clocks
      release_rst();
      for (int k = 1; k <= 4; k++) begin
         run(2);
         chk_pc("nop_pc", k[15:0]);
         chk("nop_rw", {31'h0, rWMem}, 32'h1);
         chk("nop_dout", {24'h0, dBusOut}, 32'h0);
      end

      // LDI r0,0x5A ; ST [0x1234],r0 ; HALT
      rst = 1'b0;
      clear_mem();
      put(16'h0000, 8'h02); put(16'h0001, 8'h5A);
      put(16'h0002, 8'h84); put(16'h0003, 8'h34); put(16'h0004, 8'h12);
      put(16'h0005, 8'h07);
      expect_wr(16'h1234, 8'h5A);
      release_rst();
      run(8);
      chk_pc("st_next_fetch", 16'h0005);
      run(20);
      chk_pc("halt_pc", 16'h0006);
      chk("halt_addr", {16'h0, addrBus}, 32'h0006);
      chk("halt_rw", {31'h0, rWMem}, 32'h1);

      // Same program, reset asserted during the write cycle
      rst = 1'b0;
      expect_wr(16'h1234, 8'h5A);
      release_rst();
      run(7);
      #2 rst = 1'b0;
      #1;
      chk("arst_addr", {16'h0, addrBus}, 32'h0);
      chk("arst_rw", {31'h0, rWMem}, 32'h1);
      chk("arst_dout", {24'h0, dBusOut}, 32'h0);
      chk_pc("arst_pc", 16'h0000);

      // Registers must be cleared by that reset: ST [0x3000],r0 writes 0x00
      clear_mem();
      put(16'h0000, 8'h04); put(16'h0001, 8'h00); put(16'h0002, 8'h30);
      put(16'h0003, 8'h07);
      expect_wr(16'h3000, 8'h00);
      release_rst();
      run(5);
      chk_pc("clr_st_pc", 16'h0003);

      // LD r1,[0x1000] ; ST [0x2000],r1 ; HALT
      rst = 1'b0;
      clear_mem();
      put(16'h0000, 8'h2B); put(16'h0001, 8'h00); put(16'h0002, 8'h10);
      put(16'h0003, 8'h0C); put(16'h0004, 8'h00); put(16'h0005, 8'h20);
      put(16'h0006, 8'h07);
      put(16'h1000, 8'hA5);
      expect_wr(16'h2000, 8'hA5);
      release_rst();
      run(5);
      chk_pc("ld_next_fetch", 16'h0003);
      run(9);
      chk_pc("ld_halt_pc", 16'h0007);

      // ALU, flags and conditional branch
      rst = 1'b0;
      clear_mem();
      put(16'h0000, 8'h02); put(16'h0001, 8'hFF);                        // LDI r0,FF
      put(16'h0002, 8'h22); put(16'h0003, 8'h01);                        // LDI r1,01
      put(16'h0004, 8'h0D);                                              // ADD r0,r1
      put(16'h0005, 8'h86); put(16'h0006, 8'h00); put(16'h0007, 8'h01);  // JZ 0x0100
      put(16'h0100, 8'h04); put(16'h0101, 8'h00); put(16'h0102, 8'h30);  // ST [3000],r0
      put(16'h0103, 8'hA5);                                              // SUB r1,r0
      put(16'h0104, 8'h86); put(16'h0105, 8'h00); put(16'h0106, 8'h02);  // JZ 0x0200
      put(16'h0107, 8'h0C); put(16'h0108, 8'h01); put(16'h0109, 8'h30);  // ST [3001],r1
      put(16'h010A, 8'h49);                                              // MOV r2,r1
      put(16'h010B, 8'h55);                                              // ADD r2,r2
      put(16'h010C, 8'h14); put(16'h010D, 8'h02); put(16'h010E, 8'h30);  // ST [3002],r2
      put(16'h010F, 8'h07);
      expect_wr(16'h3000, 8'h00);
      expect_wr(16'h3001, 8'h01);
      expect_wr(16'h3002, 8'h02);
      release_rst();
      run(12);
      chk_pc("jz_taken_pc", 16'h0100);
      run(11);
      chk_pc("jz_not_taken_pc", 16'h0107);
      run(14);
      chk_pc("alu_end_fetch", 16'h010F);
      run(8);
      chk_pc("alu_halt_pc", 16'h0110);

      // JMP 0xFFFF onto a NOP: PC wraps to 0x0000
      rst = 1'b0;
      clear_mem();
      put(16'h0000, 8'h06); put(16'h0001, 8'hFF); put(16'h0002, 8'hFF);
      release_rst();
      run(4);
      chk_pc("jmp_pc", 16'hFFFF);
      chk("jmp_addr", {16'h0, addrBus}, 32'hFFFF);
      run(2);
      chk_pc("wrap_pc", 16'h0000);

      run(2);
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL missing_writes: got %0d pending expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/control.md
# control

Instruction-sequencing control unit of the chip-Z8 8-bit CPU core. It owns the program counter, instruction register, a four-entry 8-bit register file and Z/C flags, and fetches and executes instructions over a single shared byte-wide memory bus with a 16-bit address. It sits between the external memory and the rest of the core. `pcOutTest` exports the PC for bench observation.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- dBusIn  input  8  read data from memory, sampled on the rising edge that ends a read cycle.
- dBusOut  output  8  write data; valid only while rWMem=0, otherwise 0x00.
- rWMem  output  1  1 = read, 0 = write.
- addrBus  output  16  memory address for the current cycle.
- pcOutTest  output  16  current PC value (debug/test).

## Operation
- State: PC[15:0], IR[7:0], r0..r3[7:0], Z, C, operand latches LO/HI[7:0], FSM state.
- Instruction byte fields: b7 = mode, b6:5 = rd, b4:3 = rs, b2:0 = op.
- Opcodes:
  - 000 NOP.
  - 001 MOV rd←rs.
  - 010 LDI rd←imm8, where imm8 is the next byte.
  - 011 LD rd←mem[{HI,LO}], with a 2-byte address following, low byte first.
  - 100 ST mem[{HI,LO}]←rs, 2-byte address.
  - 101 b7=0 ADD rd←rd+rs, b7=1 SUB rd←rd−rs.
  - 110 b7=0 JMP {HI,LO}, b7=1 JZ (jump only if Z=1).
  - 111 HALT.
- b7 is ignored for ops other than 101 and 110.
- Flags: only ADD/SUB update them. Z = (result==0). C = carry-out for ADD, borrow for SUB.
- FSM states: FETCH, DECODE, OPLO, OPHI, MEM, HALT.
  - FETCH: addrBus=PC, read; IR←dBusIn; PC←PC+1; → DECODE.
  - DECODE: NOP/MOV/ADD/SUB execute here and go → FETCH. HALT → HALT. LDI/LD/ST/JMP/JZ → OPLO.
  - OPLO: addrBus=PC, read; PC←PC+1. LDI writes rd←dBusIn and goes → FETCH. Other ops: LO←dBusIn, → OPHI.
  - OPHI: addrBus=PC, read; HI←dBusIn; PC←PC+1.
    - JMP, and JZ with Z=1: PC←{dBusIn,LO}; → FETCH.
    - JZ with Z=0: → FETCH, PC remains the incremented value.
    - LD/ST: → MEM.
  - MEM: addrBus={HI,LO}. LD: read, rd←dBusIn. ST: rWMem=0, dBusOut=rs. Then → FETCH.
  - HALT: addrBus=PC, read, no state change until reset.
- PC arithmetic is modulo 2^16: 0xFFFF+1 = 0x0000. Register arithmetic is modulo 2^8.
- Outputs addrBus, rWMem, dBusOut and pcOutTest are Moore decodes of state and registers, with no combinational path from dBusIn.

## Timing
- Reset (rst=0, asynchronous) sets:
  - PC=0x0000, state FETCH, IR, LO, HI, r0..r3, Z and C all 0.
  - Outputs: addrBus=0x0000, rWMem=1, dBusOut=0x00, pcOutTest=0x0000.
- On rst deassertion, the first rising edge completes the fetch from 0x0000.
- Cycles per instruction:
  - NOP/MOV/ADD/SUB: 2.
  - LDI: 3.
  - JMP/JZ: 4.
  - LD/ST: 5.
- Memory is combinational-read: dBusIn must be valid before the rising edge ending each read cycle.
- A write occurs during the single MEM cycle with rWMem=0. rWMem is 1 in every other cycle.
- MOV/ADD/SUB with rd==rs use the old value of the register.
- Reset asserted mid-instruction aborts it immediately. No partial register write happens after assertion.

## Test plan
- Reset, then dBusIn=0x00 constant: pcOutTest steps 0,1,2,… once every 2 clocks; rWMem stays 1; dBusOut=0x00.
- Apply reset mid-instruction: all outputs return to reset values immediately, asynchronously, without waiting for a clock edge.
- Memory image 0x0000: 02 5A (LDI r0,0x5A), 0x0002: 84 34 12 (ST [0x1234],r0):
  - Write cycle shows addrBus=0x1234, rWMem=0, dBusOut=0x5A.
  - Next FETCH is at 0x0005.
- Memory image 0x0000: 2B 00 10 (LD r1,[0x1000]) with mem[0x1000]=0xA5, then ST r1 to 0x2000: write shows dBusOut=0xA5.
- Memory image: LDI r0,0xFF; LDI r1,0x01; ADD r0,r1 → r0=0x00, Z=1, C=1. Then JZ 0x0100: pcOutTest=0x0100 on the next FETCH. Then SUB producing a nonzero result plus JZ → no jump.
- Memory image: JMP 0xFFFF with 0x00 at 0xFFFF: PC wraps to 0x0000 after the NOP. HALT (0x07): PC and outputs frozen until reset.
